// File: rtl/tree_cmp_pkg.sv
// Shared types and helpers for the pipelined magnitude comparator tree.
package tree_cmp_pkg;

    typedef struct packed {
        logic g;
        logic l;
    } cmp_pair_t;

    // Higher-significance pair dominates; the lower pair decides only on a tie.
    function automatic cmp_pair_t cmp_merge(cmp_pair_t hi, cmp_pair_t lo);
        cmp_pair_t r;
        r.g = hi.g | (~hi.l & lo.g);
        r.l = hi.l | (~hi.g & lo.l);
        return r;
    endfunction

    // First flat index of tree level k (k >= 1) when levels are packed back to back.
    function automatic int unsigned lvl_offset(int unsigned width, int unsigned k);
        return width - (width >> (k - 1));
    endfunction

endpackage

// File: rtl/cmp_tree_node.sv
// Combinational merge node: folds a high/low compare pair into one.
module cmp_tree_node
    import tree_cmp_pkg::*;
(
    input  cmp_pair_t hi,
    input  cmp_pair_t lo,
    output cmp_pair_t y
);

    assign y = cmp_merge(hi, lo);

endmodule

// File: rtl/pipelined_tree_comparator.sv
// Pipelined signed/unsigned magnitude comparator: one registered merge level per
// tree level, global-stall flow control.
module pipelined_tree_comparator
    import tree_cmp_pkg::*;
#(
    parameter  int unsigned WIDTH  = 16,
    localparam int unsigned LEVELS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int unsigned NODES = WIDTH - 1;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipelined_tree_comparator: WIDTH must be a power of two >= 2");
    end

    cmp_pair_t             leaf_c  [WIDTH];
    cmp_pair_t             node_c  [NODES];
    cmp_pair_t             stage_q [NODES];
    logic      [LEVELS-1:0] vld_q;
    logic                   adv;

    // Leaf pairs; the sign bit swaps roles in two's-complement mode.
    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
        if (i == WIDTH - 1) begin : g_msb
            assign leaf_c[i] = signed_mode ? '{g: ~a[i] & b[i],  l: a[i] & ~b[i]}
                                           : '{g: a[i] & ~b[i],  l: ~a[i] & b[i]};
        end else begin : g_lsb
            assign leaf_c[i] = '{g: a[i] & ~b[i], l: ~a[i] & b[i]};
        end
    end

    // Level k merges the previous level (leaves for k=1) into WIDTH>>k pairs.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned N   = WIDTH >> k;
        localparam int unsigned OFF = lvl_offset(WIDTH, k);
        for (genvar j = 0; j < N; j++) begin : g_node
            cmp_pair_t hi_c;
            cmp_pair_t lo_c;
            cmp_pair_t y_c;
            if (k == 1) begin : g_from_leaf
                assign hi_c = leaf_c[2*j+1];
                assign lo_c = leaf_c[2*j];
            end else begin : g_from_stage
                localparam int unsigned SRC = lvl_offset(WIDTH, k - 1);
                assign hi_c = stage_q[SRC+2*j+1];
                assign lo_c = stage_q[SRC+2*j];
            end
            cmp_tree_node u_node (
                .hi (hi_c),
                .lo (lo_c),
                .y  (y_c)
            );
            assign node_c[OFF+j] = y_c;
        end
    end

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Whole pipeline moves or holds as one; bubbles travel with their slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '{default: '0};
            vld_q   <= '0;
        end else if (adv) begin
            stage_q <= node_c;
            vld_q   <= (vld_q << 1) | LEVELS'(in_valid);
        end
    end

    assign out_valid = vld_q[LEVELS-1];
    assign gt        = stage_q[NODES-1].g;
    assign lt        = stage_q[NODES-1].l;
    assign eq        = ~stage_q[NODES-1].g & ~stage_q[NODES-1].l;

endmodule

// File: tb/tb_pipelined_tree_comparator.sv
// Scoreboard bench for pipelined_tree_comparator (WIDTH=16): directed cases,
// backpressure, mid-flight reset and random traffic against a reference compare.
module tb_pipelined_tree_comparator;

    localparam int unsigned W   = 16;
    localparam int          LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         signed_mode;
    logic         out_valid;
    logic         out_ready;
    logic         gt;
    logic         lt;
    logic         eq;

    pipelined_tree_comparator #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .gt          (gt),
        .lt          (lt),
        .eq          (eq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] res;   // {gt, lt, eq}
        int         acc;
        bit         lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] ref_cmp(logic [W-1:0] x, logic [W-1:0] y, bit m);
        int sx;
        int sy;
        if (m) begin
            sx = int'(x) - ((x >= 16'h8000) ? 65536 : 0);
            sy = int'(y) - ((y >= 16'h8000) ? 65536 : 0);
        end else begin
            sx = int'(x);
            sy = int'(y);
        end
        if (sx > sy) return 3'b100;
        if (sx < sy) return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock of stimulus; returns whether the DUT accepts the offered pair.
    task automatic step(input bit iv, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input bit m, input bit orr, input bit lat, input bit rel,
                        output bit acc);
        exp_t e;
        @(posedge clk);
        #1;
        if (rel) rst_n = 1'b1;
        in_valid    = iv;
        a           = ta;
        b           = tb_v;
        signed_mode = m;
        out_ready   = orr;
        @(negedge clk);
        acc = iv && in_ready;
        if (acc) begin
            e.res = ref_cmp(ta, tb_v, m);
            e.acc = cyc;
            e.lat = lat;
            q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_gt"},        32'(gt),        32'd0);
        check({tag, "_lt"},        32'(lt),        32'd0);
        check({tag, "_eq"},        32'(eq),        32'd1);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    // Monitor: checks every delivered result plus the handshake invariants.
    initial begin
        bit         stall_prev = 1'b0;
        logic [2:0] prev       = 3'b000;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            if (out_valid)
                check("onehot", 32'(int'(gt) + int'(lt) + int'(eq)), 32'd1);
            if (stall_prev) begin
                check("stall_valid_hold", 32'(out_valid), 32'd1);
                check("stall_data_hold", 32'({gt, lt, eq}), 32'(prev));
            end
            if (out_valid && !out_ready)
                check("in_ready_stall", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_output: got gt/lt/eq %b with nothing expected", {gt, lt, eq});
                end else begin
                    e = q.pop_front();
                    check("result", 32'({gt, lt, eq}), 32'(e.res));
                    if (e.lat) check("latency", 32'(cyc - e.acc), 32'(LAT));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev       = {gt, lt, eq};
        end
    end

    initial begin
        bit acc;
        int sent;
        int tries;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Unsigned greater-than, offered on the very first edge after release.
        step(1, 16'h1234, 16'h1233, 0, 1, 1, 1, acc);
        check("accept_after_release", 32'(acc), 32'd1);
        repeat (6) step(0, '0, '0, 0, 1, 0, 0, acc);

        // Same operands, signed then unsigned, back to back; then equality/extremes.
        step(1, 16'h8000, 16'h0001, 1, 1, 1, 0, acc);
        step(1, 16'h8000, 16'h0001, 0, 1, 1, 0, acc);
        step(1, 16'hFFFF, 16'hFFFF, 0, 1, 1, 0, acc);
        step(1, 16'hFFFF, 16'hFFFF, 1, 1, 1, 0, acc);
        step(1, 16'h0000, 16'hFFFF, 1, 1, 1, 0, acc);
        step(1, 16'h0000, 16'hFFFF, 0, 1, 1, 0, acc);
        repeat (6) step(0, '0, '0, 0, 1, 0, 0, acc);

        // Six back-to-back compares with a three-cycle consumer stall.
        sent = 0;
        for (int c = 0; c < 30 && sent < 6; c++) begin
            step(1, 16'(16'h0100 + 16'(sent * 7)), 16'h0103, sent[0], !(c inside {5, 6, 7}), 0, 0, acc);
            if (acc) sent++;
        end
        check("bp_sent", 32'(sent), 32'd6);
        repeat (8) step(0, '0, '0, 0, 1, 0, 0, acc);
        check("bp_drained", 32'(q.size()), 32'd0);

        // Reset with three results in flight: all must vanish.
        step(1, 16'h0005, 16'h0009, 0, 1, 0, 0, acc);
        step(1, 16'h0009, 16'h0005, 0, 1, 0, 0, acc);
        step(1, 16'h7777, 16'h7777, 0, 1, 0, 0, acc);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q.delete();
        repeat (2) @(posedge clk);
        step(1, 16'hFFFE, 16'h0002, 1, 1, 1, 1, acc);
        check("accept_after_midreset", 32'(acc), 32'd1);
        repeat (8) step(0, '0, '0, 0, 1, 0, 0, acc);
        check("midreset_drained", 32'(q.size()), 32'd0);

        // Random traffic with random consumer backpressure.
        sent  = 0;
        tries = 0;
        while (sent < 10000 && tries < 40000) begin
            step($urandom_range(9, 0) < 8, 16'($urandom), 16'($urandom), 1'($urandom),
                 $urandom_range(9, 0) < 7, 0, 0, acc);
            if (acc) sent++;
            tries++;
        end
        check("random_sent", 32'(sent), 32'd10000);

        tries = 0;
        while (q.size() != 0 && tries < 200) begin
            step(0, '0, '0, 0, 1, 0, 0, acc);
            tries++;
        end
        check("final_drain", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_tree_comparator.md
PIPELINED_TREE_COMPARATOR -- requirements
Module: pipelined_tree_comparator

Interface
REQ-001 Parameter WIDTH, default 16: operand width; SHALL be a power of two, at least 2.
REQ-002 Parameter LEVELS, default $clog2(WIDTH): number of merge levels; SHALL be derived, not overridden.
REQ-003 Port clk, input, 1: single clock; all state SHALL be updated on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: operand pair and mode present.
REQ-006 Port in_ready, output, 1: pipeline accepts the operand pair this cycle.
REQ-007 Port a, input, WIDTH: operand A.
REQ-008 Port b, input, WIDTH: operand B.
REQ-009 Port signed_mode, input, 1: 1 = two's-complement compare, 0 = unsigned compare.
REQ-010 Port out_valid, output, 1: result present.
REQ-011 Port out_ready, input, 1: consumer takes the result this cycle.
REQ-012 Port gt, output, 1: A > B.
REQ-013 Port lt, output, 1: A < B.
REQ-014 Port eq, output, 1: A == B.

Function
REQ-015 Leaf stage (combinational) SHALL form per-bit pairs g[i] = a[i] & ~b[i] and l[i] = ~a[i] & b[i].
REQ-016 In signed mode, the leaf for bit WIDTH-1 SHALL swap its roles: g = ~a & b, l = a & ~b.
REQ-017 Each merge node (high pair H, low pair L) SHALL compute g = gH | (~lH & gL) and l = lH | (~gH & lL).
REQ-018 Each merge level SHALL halve the pair count; level k holds WIDTH/2^k pairs, and its output SHALL be registered.
REQ-019 Each level register SHALL carry a valid bit alongside its pairs.
REQ-020 Latency: a pair accepted in cycle N SHALL appear on gt/lt/eq with out_valid=1 in cycle N+LEVELS, absent stalls (4 cycles for WIDTH=16).
REQ-021 Outputs SHALL be driven as gt = final g, lt = final l, and eq = ~gt & ~lt.
REQ-022 Exactly one of gt/lt/eq SHALL be 1 whenever out_valid=1.
REQ-023 The global advance enable SHALL be adv = out_ready | ~out_valid, and in_ready SHALL equal adv.
REQ-024 When adv=1, every level SHALL shift forward, and level 1 SHALL load the leaf result with valid = in_valid.
REQ-025 When adv=0, all level registers including valid bits SHALL hold; out_valid and gt/lt/eq SHALL stay stable.
REQ-026 Bubbles SHALL NOT be collapsed during a stall (global-stall pipeline).
REQ-027 Throughput SHALL be one compare per cycle while out_ready=1.
REQ-028 When in_valid=0 and adv=1, a bubble (valid=0) SHALL enter level 1.
REQ-029 signed_mode SHALL be sampled with its operands, so per-transaction mode changes are honoured back-to-back.
REQ-030 A simultaneous accept and output handshake in the same cycle SHALL be legal and lossless.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear all level valid bits and all g/l pair registers to 0.
REQ-032 During reset, out_valid SHALL be 0, gt=0, lt=0, eq=1, and in_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight results; no stale result shall appear after release.
REQ-034 The first accept after release SHALL be possible on the first rising edge with rst_n=1.

Structure
REQ-035 The shared package tree_cmp_pkg SHALL define typedef cmp_pair_t (struct: g, l) and the merge function cmp_merge(hi, lo).
REQ-036 The merge node SHALL be one sub-module, cmp_tree_node (two cmp_pair_t in, one out, combinational), instantiated WIDTH-1 times via generate.
REQ-037 Level registers and valid chain SHALL live in pipelined_tree_comparator; no other sub-modules.

Verification (WIDTH=16)
REQ-038 Unsigned: a=0x1234, b=0x1233, signed_mode=0, out_ready=1 -> gt=1 and out_valid=1 exactly 4 cycles after accept.
REQ-039 Signed: a=0x8000, b=0x0001, signed_mode=1 -> lt=1; same operands with signed_mode=0 -> gt=1, issued back-to-back on consecutive cycles.
REQ-040 Equality and extremes: a=b=0xFFFF -> eq=1; a=0x0000, b=0xFFFF, signed_mode=1 -> gt=1.
REQ-041 Backpressure: 6 back-to-back compares, out_ready=0 for 3 cycles mid-stream -> in_ready=0 while out_valid=1, outputs stable, all 6 results delivered in order, none lost or duplicated.
REQ-042 Reset mid-flight: assert rst_n=0 with 3 transactions in flight -> out_valid=0 immediately; after release, no output until a new accept plus 4 cycles.
REQ-043 Random: 10k random a/b/signed_mode with random out_ready -> scoreboard against reference compare; the one-hot gt/lt/eq assertion holds every valid cycle.
